// File: rtl/systolic_row_feeder.sv
// Streams rows from the unified buffer into systolic_data_setup through a 2-entry row buffer.
// Define SYSTOLIC_FEEDER_FLUSH_EN to append MATRIX_WIDTH-1 zero rows that drain the skew pipeline.
module systolic_row_feeder #(
    parameter int unsigned MATRIX_WIDTH = 14,
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned LENGTH_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr_i,
    input  logic [LENGTH_WIDTH-1:0]      cmd_length_i,
    input  logic                         stall_i,
    output logic                         buf_rd_en_o,
    output logic [ADDR_WIDTH-1:0]        buf_rd_addr_o,
    input  logic [MATRIX_WIDTH-1:0][7:0] buf_rd_data_i,
    output logic                         setup_enable_o,
    output logic [MATRIX_WIDTH-1:0][7:0] setup_data_out_o,
    output logic                         row_valid_o,
    output logic                         busy_o,
    output logic                         done_o
);

    typedef logic [MATRIX_WIDTH-1:0][7:0] row_t;

`ifdef SYSTOLIC_FEEDER_FLUSH_EN
    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;
    localparam int unsigned FlushW = $clog2(MATRIX_WIDTH);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(MATRIX_WIDTH - 2);
    logic [FlushW-1:0] flush_cnt_d, flush_cnt_q;
    logic              row_valid_d, row_valid_q;
`else
    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;
`endif

    state_e                  state_d, state_q;
    logic [ADDR_WIDTH-1:0]   addr_d, addr_q;
    logic [LENGTH_WIDTH-1:0] len_d, len_q;
    logic [LENGTH_WIDTH-1:0] issued_d, issued_q;
    logic [LENGTH_WIDTH-1:0] popped_d, popped_q;
    logic                    pend_d, pend_q;
    logic [1:0]              cnt_d, cnt_q;
    row_t                    head_d, head_q;
    row_t                    next_d, next_q;

    logic       pop, last_pop, issue;
    logic [1:0] occ_after;

    // Occupancy counts the in-flight read plus held rows; after this cycle's pop it is also
    // the next held-row count, since the in-flight read always lands next cycle.
    always_comb begin
        pop       = (state_q == StRead) && (cnt_q != 2'd0) && !stall_i;
        last_pop  = pop && (popped_q == len_q - LENGTH_WIDTH'(1));
        occ_after = cnt_q + {1'b0, pend_q} - {1'b0, pop};
        issue     = (state_q == StRead) && (issued_q != len_q) && (occ_after < 2'd2);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        popped_d = popped_q;
        pend_d   = issue;
        cnt_d    = occ_after;
        head_d   = head_q;
        next_d   = next_q;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
        row_valid_d = row_valid_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d   = cmd_addr_i;
                    len_d    = cmd_length_i;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (cmd_length_i == '0) ? StDone : StRead;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
                    row_valid_d = 1'b1;
`endif
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LENGTH_WIDTH'(1);
                end
                if (pop) popped_d = popped_q + LENGTH_WIDTH'(1);
                if (last_pop) begin
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                    row_valid_d = 1'b0;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
            StFlush: begin
                if (!stall_i) begin
                    if (flush_cnt_q == FlushLast) state_d = StDone;
                    else flush_cnt_d = flush_cnt_q + FlushW'(1);
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // head_q is the presented row; next_q catches a return that arrives behind it.
        if (pop) begin
            if (cnt_q == 2'd2) begin
                head_d = next_q;
                if (pend_q) next_d = buf_rd_data_i;
            end else if (pend_q) begin
                head_d = buf_rd_data_i;
            end
        end else if (pend_q) begin
            if (cnt_q == 2'd0) head_d = buf_rd_data_i;
            else next_d = buf_rd_data_i;
        end
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
        if (last_pop) head_d = '0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= 2'd0;
            head_q   <= '0;
            next_q   <= '0;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
            flush_cnt_q <= '0;
            row_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            next_q   <= next_d;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
            row_valid_q <= row_valid_d;
`endif
        end
    end

    assign cmd_ready_o      = (state_q == StIdle);
    assign buf_rd_en_o      = issue;
    assign buf_rd_addr_o    = addr_q;
    assign setup_data_out_o = head_q;
    assign done_o           = (state_q == StDone);
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
    assign setup_enable_o = pop || ((state_q == StFlush) && !stall_i);
    assign busy_o         = (state_q == StRead) || (state_q == StFlush);
    assign row_valid_o    = row_valid_q;
`else
    assign setup_enable_o = pop;
    assign busy_o         = (state_q == StRead);
    assign row_valid_o    = 1'b1;
`endif

endmodule
